// File: rtl/issue_sched.sv
// issue_sched: dual-issue scheduler choosing 0/1/2 in-order issues from the two buffer heads
module issue_sched #(
    parameter int DIV_LAT = 8,
    parameter int CW      = 5
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       flush,
    input  logic       stall,
    input  logic       h0_valid,
    input  logic [4:0] h0_rs1,
    input  logic [4:0] h0_rs2,
    input  logic       h0_use_rs1,
    input  logic       h0_use_rs2,
    input  logic       h0_rf_we,
    input  logic [4:0] h0_rd,
    input  logic       h0_is_mem,
    input  logic       h0_is_load,
    input  logic       h0_is_br,
    input  logic       h0_is_div,
    input  logic       h1_valid,
    input  logic [4:0] h1_rs1,
    input  logic [4:0] h1_rs2,
    input  logic       h1_use_rs1,
    input  logic       h1_use_rs2,
    input  logic       h1_rf_we,
    input  logic [4:0] h1_rd,
    input  logic       h1_is_mem,
    input  logic       h1_is_load,
    input  logic       h1_is_br,
    input  logic       h1_is_div,
    output logic       issue_a,
    output logic       issue_b,
    output logic [1:0] pop_cnt,
    output logic       div_busy,
    output logic [1:0] sched_state
);
    typedef enum logic [1:0] {RUN = 2'd0, DIV_BUSY = 2'd1, FLUSH_BUB = 2'd2} state_t;
    state_t        state;
    logic [CW-1:0] div_cnt;
    logic          ld_vld;
    logic [4:0]    ld_rd;
    logic          lu0, lu1, raw, waw, div_iss;
    logic          unused_h1_br;
    assign unused_h1_br = h1_is_br;
    assign sched_state  = state;
    // hazard detection and issue decision; gated by rstn so nothing issues in reset
    always_comb begin
        lu0     = ld_vld && ld_rd != 5'd0 &&
                  ((h0_use_rs1 && h0_rs1 == ld_rd) || (h0_use_rs2 && h0_rs2 == ld_rd));
        lu1     = ld_vld && ld_rd != 5'd0 &&
                  ((h1_use_rs1 && h1_rs1 == ld_rd) || (h1_use_rs2 && h1_rs2 == ld_rd));
        raw     = h0_rf_we && h0_rd != 5'd0 &&
                  ((h1_use_rs1 && h1_rs1 == h0_rd) || (h1_use_rs2 && h1_rs2 == h0_rd));
        waw     = h0_rf_we && h1_rf_we && h0_rd == h1_rd && h0_rd != 5'd0;
        issue_a = rstn && !flush && !stall && state != FLUSH_BUB && h0_valid && !lu0 &&
                  !(h0_is_div && div_busy);
        issue_b = issue_a && h1_valid && !lu1 && !raw && !waw && !(h0_is_mem && h1_is_mem) &&
                  !h0_is_br && !(h1_is_div && (div_busy || h0_is_div));
        pop_cnt = {issue_a & issue_b, issue_a ^ issue_b};
        div_iss = (issue_a && h0_is_div) || (issue_b && h1_is_div);
    end
    // scheduler FSM, divider occupancy counter and load-use tracker; flush overrides everything
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= RUN;
            div_cnt  <= '0;
            div_busy <= 1'b0;
            ld_vld   <= 1'b0;
            ld_rd    <= 5'd0;
        end else if (flush) begin
            state    <= FLUSH_BUB;
            div_cnt  <= '0;
            div_busy <= 1'b0;
            ld_vld   <= 1'b0;
        end else begin
            if (!stall) begin
                ld_vld <= (issue_a && h0_is_load) || (issue_b && h1_is_load);
                if (issue_b && h1_is_load)
                    ld_rd <= h1_rd;
                else if (issue_a && h0_is_load)
                    ld_rd <= h0_rd;
            end
            case (state)
                RUN: if (div_iss) begin
                    state    <= DIV_BUSY;
                    div_busy <= 1'b1;
                    div_cnt  <= CW'(DIV_LAT - 1);
                end
                DIV_BUSY: if (div_cnt == CW'(1)) begin
                    state    <= RUN;
                    div_busy <= 1'b0;
                    div_cnt  <= '0;
                end else
                    div_cnt <= div_cnt - 1'b1;
                default: state <= RUN;
            endcase
        end
    end
endmodule
